// File: rtl/pipe_pkg.sv
// Shared types for the pipe_stage valid/ready register slice.
// Holds default width, occupancy type and main-slot source select.
package pipe_pkg;

   localparam int DEFAULT_WIDTH = 32;

   // Number of held entries, 0..2.
   typedef logic [1:0] occ_t;

   // Source feeding the main slot on a load.
   typedef enum logic [0:0] {
      SEL_IN   = 1'b0,
      SEL_SKID = 1'b1
   } slot_sel_e;

   function automatic occ_t occ_count(input logic main_v,
                                      input logic skid_v);
      occ_t n;
      n = {1'b0, main_v} + {1'b0, skid_v};
      return n;
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: a valid bit plus WIDTH bits of payload.
// Ports: clk, rst (sync, active high), load/clear strobes, d in, valid/q out.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int                WIDTH     = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic             valid,
   output logic [WIDTH-1:0] q
);

   // Clear wins over load so a squash can never be overridden.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         valid <= 1'b0;
         q     <= RESET_VAL;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end
   end

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline register with optional skid slot.
// Macro PIPE_STAGE_SKID_EN: defined -> two slots, registered in_ready;
// undefined -> single slot, in_ready = !out_valid || out_ready.
// Ports: clk, rst (sync, active high), flush, in_valid/in_ready/in_data,
// out_valid/out_ready/out_data, occupancy (held entries 0..2).
module pipe_stage
   import pipe_pkg::*;
#(
   parameter int                WIDTH     = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output occ_t             occupancy
);

   logic             main_v;
   logic [WIDTH-1:0] main_q;
   logic             main_load;
   logic             main_clear;
   logic [WIDTH-1:0] main_d;
   logic             accept;
   logic             consume;

   assign accept  = in_valid && in_ready;
   assign consume = main_v && out_ready;

   assign out_valid = main_v;
   assign out_data  = main_q;

`ifdef PIPE_STAGE_SKID_EN

   logic             skid_v;
   logic [WIDTH-1:0] skid_q;
   logic             skid_load;
   logic             skid_clear;
   slot_sel_e        sel;

   // Registered ready: depends only on skid state, never on out_ready.
   assign in_ready = !skid_v;

   // A valid skid entry is always older than anything at the input,
   // so it has first claim on main.
   assign sel = skid_v ? SEL_SKID : SEL_IN;

   always_comb begin
      main_d = in_data;
      unique case (sel)
         SEL_SKID: main_d = skid_q;
         SEL_IN:   main_d = in_data;
         default:  main_d = in_data;
      endcase
   end

   always_comb begin
      main_load  = 1'b0;
      skid_load  = 1'b0;
      main_clear = 1'b0;
      skid_clear = 1'b0;
      if (flush) begin
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else begin
         if (skid_v) begin
            // Skid full means in_ready is low: no input accepted.
            main_load  = consume;
            skid_clear = consume;
         end else begin
            main_load = accept && (!main_v || consume);
            skid_load = accept && main_v && !consume;
         end
         main_clear = consume && !main_load;
      end
   end

   pipe_slot #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (in_data),
      .valid (skid_v),
      .q     (skid_q)
   );

   assign occupancy = occ_count(main_v, skid_v);

`else

   // No skid: ready when main is empty or drains this cycle.
   assign in_ready = !main_v || out_ready;
   assign main_d   = in_data;

   always_comb begin
      main_load  = 1'b0;
      main_clear = 1'b0;
      if (flush) begin
         main_clear = 1'b1;
      end else begin
         main_load  = accept;
         main_clear = consume && !accept;
      end
   end

   assign occupancy = occ_count(main_v, 1'b0);

`endif

   pipe_slot #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_main (
      .clk   (clk),
      .rst   (rst),
      .load  (main_load),
      .clear (main_clear),
      .d     (main_d),
      .valid (main_v),
      .q     (main_q)
   );

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard testbench for pipe_stage (skid and no-skid builds).
// Directed vectors plus a short random valid/ready phase.
module tb_pipe_stage;
   import pipe_pkg::*;

   localparam int          W    = 32;
   localparam logic [W-1:0] RV  = 32'hA5A5_0000;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   occ_t         occupancy;

   int checks = 0;
   int fails  = 0;
   int outs   = 0;
   logic [W-1:0] sb[$];

   always #5 clk = ~clk;

   pipe_stage #(
      .WIDTH     (W),
      .RESET_VAL (RV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   // Monitor: inputs change at posedge+1, so negedge sees settled values.
   always @(negedge clk) begin
      if (rst || flush) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            checks++;
            outs++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL sb_unexpected got=%h required=none", out_data);
            end else begin
               logic [W-1:0] e;
               e = sb.pop_front();
               if (out_data !== e) begin
                  fails++;
                  $display("FAIL sb_data got=%h required=%h", out_data, e);
               end
            end
         end
         if (in_valid && in_ready) sb.push_back(in_data);
      end
   end

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold one entry on the input until it is accepted (bounded).
   task automatic send(input logic [W-1:0] d);
      bit ok;
      ok = 0;
      in_valid = 1'b1;
      in_data  = d;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      step();
      in_valid = 1'b0;
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      out_ready = 1'b1;
      for (int k = 0; k < 50; k++) begin
         if (!out_valid && sb.size() == 0) begin
            ok = 1;
            break;
         end
         step();
      end
      if (!ok) chk("drain_timeout", 0, 1);
   endtask

   initial begin
      int good;
      int lows;
      int o0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
      in_data = '0; out_ready = 1'b0;
      step(); step();

      chk("rst_out_valid", out_valid, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, RV);
      rst = 1'b0;
      step();

      // Single pass
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'hDEAD0001;
      step();
      in_valid = 1'b0;
      chk("single_valid", out_valid, 1);
      chk("single_data", out_data, 32'hDEAD0001);
      step();
      chk("single_gone", out_valid, 0);

      // Back-pressure
      out_ready = 1'b0;
      o0 = outs;
      send(32'd1);
      chk("bp_a_held", out_data, 32'd1);
`ifdef PIPE_STAGE_SKID_EN
      send(32'd2);
      chk("bp_occ2", occupancy, 2);
      chk("bp_ready0", in_ready, 0);
      in_valid = 1'b1;
      in_data  = 32'd3;
      step();
      chk("bp_c_refused", occupancy, 2);
      chk("bp_a_stable", out_data, 32'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      send(32'd3);
`else
      in_valid = 1'b1;
      in_data  = 32'd2;
      step();
      chk("bp_occ1", occupancy, 1);
      chk("bp_ready0", in_ready, 0);
      chk("bp_a_stable", out_data, 32'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      send(32'd2);
      send(32'd3);
`endif
      drain();
      chk("bp_count", outs - o0, 3);

      // Streaming 0..99
      good = 0;
      lows = 0;
      o0 = outs;
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1;
         in_data  = i;
         @(negedge clk);
         if (!in_ready) lows++;
         step();
         if (out_valid && out_data == i) good++;
      end
      in_valid = 1'b0;
      drain();
      chk("stream_per_cycle", good, 100);
      chk("stream_ready_low", lows, 0);
      chk("stream_count", outs - o0, 100);

      // Flush with stage full and an entry offered
      out_ready = 1'b0;
      send(32'h11);
`ifdef PIPE_STAGE_SKID_EN
      send(32'h22);
      chk("fl_pre_occ", occupancy, 2);
`else
      chk("fl_pre_occ", occupancy, 1);
`endif
      o0 = outs;
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'h33;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_occ", occupancy, 0);
      chk("fl_valid", out_valid, 0);
      chk("fl_data", out_data, RV);
      // Flush while the stage could accept
      out_ready = 1'b1;
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h44;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      step(); step();
      chk("fl_none_out", outs - o0, 0);
      chk("fl_idle_valid", out_valid, 0);

      // Reset mid-stream
      for (int i = 0; i < 40; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h100 + i;
         rst      = (i == 20);
         step();
         if (i == 20) begin
            chk("mrst_valid", out_valid, 0);
            chk("mrst_occ", occupancy, 0);
            chk("mrst_ready", in_ready, 1);
            chk("mrst_data", out_data, RV);
         end
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      drain();

      // Random toggling
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = $urandom;
         step();
`ifdef PIPE_STAGE_SKID_EN
         if (occupancy > 2) chk("rnd_occ", occupancy, 2);
`else
         if (occupancy > 1) chk("rnd_occ", occupancy, 1);
`endif
      end
      in_valid = 1'b0;
      drain();
      chk("sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
